// File: rtl/sobel_pkg.sv
// Shared definitions for the parametrised Sobel stream filter: output modes,
// packet FSM encoding and the 3x3 kernel weights.
package sobel_pkg;

  localparam int MODE_MAG = 0;
  localparam int MODE_BIN = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  // Indexed [row][col]; row 0 is the oldest image row in the window.
  localparam logic signed [2:0] KX [3][3] = '{
    '{-3'sd1, 3'sd0, 3'sd1},
    '{-3'sd2, 3'sd0, 3'sd2},
    '{-3'sd1, 3'sd0, 3'sd1}
  };
  localparam logic signed [2:0] KY [3][3] = '{
    '{-3'sd1, -3'sd2, -3'sd1},
    '{ 3'sd0,  3'sd0,  3'sd0},
    '{ 3'sd1,  3'sd2,  3'sd1}
  };

endpackage

// File: rtl/sobel_stream_filter_param_window.sv
// Two line buffers plus a two-column shift register; presents the 3x3 window
// that includes the pixel currently being accepted as its newest column.
module sobel_window3x3 #(
  parameter int DATA_W     = 8,
  parameter int IMG_X_SIZE = 5,
  parameter int XW         = 3
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [XW-1:0]         col,
  input  logic [DATA_W-1:0]     pixIn,
  output logic [9*DATA_W-1:0]   win
);

  // NOTE: line buffers and window registers have no reset; their contents are
  // always overwritten by the current packet before any output depends on them.
  logic [DATA_W-1:0] lineA [IMG_X_SIZE];
  logic [DATA_W-1:0] lineB [IMG_X_SIZE];
  logic [DATA_W-1:0] colOld [3];
  logic [DATA_W-1:0] colMid [3];
  logic [DATA_W-1:0] newCol [3];

  always_comb begin
    newCol[0] = lineB[col];
    newCol[1] = lineA[col];
    newCol[2] = pixIn;
    win = '0;
    for (int r = 0; r < 3; r++) begin
      win[(r*3+0)*DATA_W +: DATA_W] = colOld[r];
      win[(r*3+1)*DATA_W +: DATA_W] = colMid[r];
      win[(r*3+2)*DATA_W +: DATA_W] = newCol[r];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      lineB[col] <= lineA[col];
      lineA[col] <= pixIn;
      for (int r = 0; r < 3; r++) begin
        colOld[r] <= colMid[r];
        colMid[r] <= newCol[r];
      end
    end
  end

endmodule

// File: rtl/sobel_stream_filter_param.sv
// 3x3 Sobel edge filter on Avalon-ST raster packets with backpressure,
// magnitude/binary output and malformed-packet recovery.
module sobel_stream_filter_param
  import sobel_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                IMG_X_SIZE = 5,
  parameter int                IMG_Y_SIZE = 5,
  parameter int                MODE       = 0,
  parameter logic [DATA_W+2:0] THRESH     = 128
) (
  input  logic              csi_clkrst_clk,
  input  logic              csi_clkrst_reset,
  input  logic [DATA_W-1:0] asi_sink1_data,
  input  logic              asi_sink1_startofpacket,
  input  logic              asi_sink1_endofpacket,
  input  logic              asi_sink1_valid,
  output logic              asi_sink1_ready,
  input  logic              aso_source1_ready,
  output logic [DATA_W-1:0] aso_source1_data,
  output logic              aso_source1_startofpacket,
  output logic              aso_source1_endofpacket,
  output logic              aso_source1_valid,
  output logic              pkt_err
);

  localparam int XW = $clog2(IMG_X_SIZE);
  localparam int YW = $clog2(IMG_Y_SIZE);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_Y_SIZE - 1);

  state_t            state;
  logic [XW-1:0]     xCnt, curX;
  logic [YW-1:0]     yCnt, curY;
  logic              accept, counted, isLast, produce;
  logic [9*DATA_W-1:0] win;
  logic [DATA_W+2:0] px, magX, magY, mag;
  logic signed [DATA_W+2:0] gx, gy;
  logic [DATA_W-1:0] result;

  assign asi_sink1_ready = !aso_source1_valid | aso_source1_ready;
  assign accept          = asi_sink1_valid & asi_sink1_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    counted = 1'b0;
    curX    = xCnt;
    curY    = yCnt;
    unique case (state)
      IDLE:    counted = asi_sink1_startofpacket;
      ACTIVE:  counted = 1'b1;
      DISCARD: counted = asi_sink1_startofpacket;
      default: counted = 1'b0;
    endcase
    if (asi_sink1_startofpacket) begin
      curX = '0;
      curY = '0;
    end
    isLast  = (curX == X_LAST) && (curY == Y_LAST);
    produce = accept && counted && (curX >= XW'(2)) && (curY >= YW'(2));
  end

  sobel_window3x3 #(
    .DATA_W     (DATA_W),
    .IMG_X_SIZE (IMG_X_SIZE),
    .XW         (XW)
  ) uWindow (
    .clk   (csi_clkrst_clk),
    .en    (accept && counted),
    .col   (curX),
    .pixIn (asi_sink1_data),
    .win   (win)
  );

  always_comb begin
    gx = '0;
    gy = '0;
    px = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px = {3'b000, win[(r*3+c)*DATA_W +: DATA_W]};
        gx = gx + $signed(px) * $signed({{DATA_W{KX[r][c][2]}}, KX[r][c]});
        gy = gy + $signed(px) * $signed({{DATA_W{KY[r][c][2]}}, KY[r][c]});
      end
    end
    magX = gx[DATA_W+2] ? unsigned'(-gx) : unsigned'(gx);
    magY = gy[DATA_W+2] ? unsigned'(-gy) : unsigned'(gy);
    mag  = magX + magY;
    if (MODE == MODE_MAG)
      result = (|mag[DATA_W+2:DATA_W]) ? '1 : mag[DATA_W-1:0];
    else
      result = (mag >= THRESH) ? '1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge csi_clkrst_clk) begin
    if (csi_clkrst_reset) begin
      state                     <= IDLE;
      xCnt                      <= '0;
      yCnt                      <= '0;
      pkt_err                   <= 1'b0;
      aso_source1_valid         <= 1'b0;
      aso_source1_data          <= '0;
      aso_source1_startofpacket <= 1'b0;
      aso_source1_endofpacket   <= 1'b0;
    end else begin
      if (accept && counted) begin
        if (curX == X_LAST) begin
          xCnt <= '0;
          yCnt <= curY + YW'(1);
        end else begin
          xCnt <= curX + XW'(1);
          yCnt <= curY;
        end
        if (state == ACTIVE && asi_sink1_startofpacket) pkt_err <= 1'b1;
        if (asi_sink1_endofpacket) begin
          state <= IDLE;
          if (!isLast) pkt_err <= 1'b1;
        end else if (isLast) begin
          state   <= DISCARD;
          pkt_err <= 1'b1;
        end else begin
          state <= ACTIVE;
        end
      end else if (accept && state == DISCARD && asi_sink1_endofpacket) begin
        state <= IDLE;
      end

      // A new result may replace the one being popped in the same cycle.
      if (produce) begin
        aso_source1_valid         <= 1'b1;
        aso_source1_data          <= result;
        aso_source1_startofpacket <= (curX == XW'(2)) && (curY == YW'(2));
        aso_source1_endofpacket   <= isLast && asi_sink1_endofpacket;
      end else if (aso_source1_ready) begin
        aso_source1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter_param.sv
// Scoreboard bench: three filter instances (magnitude, binary@48, binary@49)
// share one sink stream; a reference model predicts each packet's outputs.
module tb_sobel_stream_filter_param;

  localparam int DW = 8;
  localparam int XS = 5;
  localparam int YS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sData;
  logic          sSop, sEop, sValid;
  logic          srcReady;
  int            readyMode;

  logic          sinkReady [3];
  logic [DW-1:0] oData     [3];
  logic          oSop      [3];
  logic          oEop      [3];
  logic          oValid    [3];
  logic          err       [3];

  always #5 clk = ~clk;

  sobel_stream_filter_param #(.DATA_W(DW), .IMG_X_SIZE(XS), .IMG_Y_SIZE(YS), .MODE(0), .THRESH(11'd128)) dutMag (
    .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
    .asi_sink1_data(sData), .asi_sink1_startofpacket(sSop), .asi_sink1_endofpacket(sEop),
    .asi_sink1_valid(sValid), .asi_sink1_ready(sinkReady[0]), .aso_source1_ready(srcReady),
    .aso_source1_data(oData[0]), .aso_source1_startofpacket(oSop[0]), .aso_source1_endofpacket(oEop[0]),
    .aso_source1_valid(oValid[0]), .pkt_err(err[0]));

  sobel_stream_filter_param #(.DATA_W(DW), .IMG_X_SIZE(XS), .IMG_Y_SIZE(YS), .MODE(1), .THRESH(11'd48)) dutB48 (
    .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
    .asi_sink1_data(sData), .asi_sink1_startofpacket(sSop), .asi_sink1_endofpacket(sEop),
    .asi_sink1_valid(sValid), .asi_sink1_ready(sinkReady[1]), .aso_source1_ready(srcReady),
    .aso_source1_data(oData[1]), .aso_source1_startofpacket(oSop[1]), .aso_source1_endofpacket(oEop[1]),
    .aso_source1_valid(oValid[1]), .pkt_err(err[1]));

  sobel_stream_filter_param #(.DATA_W(DW), .IMG_X_SIZE(XS), .IMG_Y_SIZE(YS), .MODE(1), .THRESH(11'd49)) dutB49 (
    .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
    .asi_sink1_data(sData), .asi_sink1_startofpacket(sSop), .asi_sink1_endofpacket(sEop),
    .asi_sink1_valid(sValid), .asi_sink1_ready(sinkReady[2]), .aso_source1_ready(srcReady),
    .aso_source1_data(oData[2]), .aso_source1_startofpacket(oSop[2]), .aso_source1_endofpacket(oEop[2]),
    .aso_source1_valid(oValid[2]), .pkt_err(err[2]));

  typedef struct {
    logic [DW-1:0] mag;
    logic [DW-1:0] b48;
    logic [DW-1:0] b49;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   img [YS][XS];
  int   passCnt  = 0;
  int   totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected outputs of a packet whose first nPix pixels (from img) were
  // accepted; a centre appears once its lower-right neighbour has arrived.
  function automatic void model_packet(input int nPix, input bit clean);
    int   gx, gy, m, trig;
    exp_t x;
    for (int cy = 1; cy <= YS - 2; cy++) begin
      for (int cx = 1; cx <= XS - 2; cx++) begin
        trig = (cy + 1) * XS + cx + 1;
        if (trig < nPix) begin
          gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
             - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
          gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
             - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
          m     = iabs(gx) + iabs(gy);
          x.mag = (m > 255) ? 8'd255 : 8'(m);
          x.b48 = (m >= 48) ? 8'd255 : 8'd0;
          x.b49 = (m >= 49) ? 8'd255 : 8'd0;
          x.sop = (cx == 1) && (cy == 1);
          x.eop = clean && (cx == XS - 2) && (cy == YS - 2);
          q.push_back(x);
        end
      end
    end
  endfunction

  // Monitor: pops one expectation per source handshake.
  always @(negedge clk) begin
    if (oValid[0] === 1'b1 && srcReady === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'(oData[0]), 32'hDEAD);
      end else begin
        e = q.pop_front();
        check("mag_data", 32'(oData[0]), 32'(e.mag));
        check("b48_data", 32'(oData[1]), 32'(e.b48));
        check("b49_data", 32'(oData[2]), 32'(e.b49));
        check("sop",      32'(oSop[0]),  32'(e.sop));
        check("eop",      32'(oEop[0]),  32'(e.eop));
        check("bin_valid_align", 32'({oValid[1], oValid[2]}), 32'h3);
      end
    end
  end

  initial begin
    srcReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       srcReady = 1'b1;
        1:       srcReady = ~srcReady;
        default: srcReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_pixel(input logic [DW-1:0] d, input bit sop, input bit eop, input int gapMax);
    int n;
    bit r;
    repeat ($urandom_range(0, gapMax)) begin
      @(posedge clk);
      #1;
    end
    sData  = d;
    sSop   = sop;
    sEop   = eop;
    sValid = 1'b1;
    n      = 0;
    do begin
      @(negedge clk);
      r = sinkReady[0];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 1000);
    if (!r) check("sink_handshake_timeout", 0, 1);
    sValid = 1'b0;
    sSop   = 1'b0;
    sEop   = 1'b0;
  endtask

  task automatic send_packet(input int nPix, input int eopIdx, input int gapMax);
    for (int i = 0; i < nPix; i++)
      send_pixel(DW'(img[i / XS][i % XS]), i == 0, i == eopIdx, gapMax);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || oValid[0] === 1'b1) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(q.size()), 0);
  endtask

  task automatic fill_ramp();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) img[y][x] = y * XS + x + 1;
  endtask

  task automatic fill_random();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) img[y][x] = int'($urandom_range(0, 255));
  endtask

  initial begin
    readyMode = 0;
    rst    = 1'b1;
    sValid = 1'b0;
    sSop   = 1'b0;
    sEop   = 1'b0;
    sData  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(oValid[0]), 0);
    check("reset_data",  32'(oData[0]),  0);
    check("reset_sop",   32'(oSop[0]),   0);
    check("reset_eop",   32'(oEop[0]),   0);
    check("reset_err",   32'(err[0]),    0);
    check("reset_ready", 32'(sinkReady[0]), 1);
    rst = 1'b0;

    // Clean ramp, free-flowing.
    fill_ramp();
    model_packet(XS * YS, 1'b1);
    send_packet(XS * YS, XS * YS - 1, 0);
    drain("ramp_drain");
    check("ramp_err", 32'(err[0]), 0);

    // Stray beats before sop are dropped; ramp with toggling ready and gaps.
    readyMode = 1;
    send_pixel(8'd200, 1'b0, 1'b0, 0);
    send_pixel(8'd7,   1'b0, 1'b1, 0);
    model_packet(XS * YS, 1'b1);
    send_packet(XS * YS, XS * YS - 1, 3);
    drain("stall_drain");
    check("stall_err", 32'(err[0]), 0);

    // Step edge saturates the magnitude.
    readyMode = 0;
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) img[y][x] = (x < 2) ? 0 : 255;
    model_packet(XS * YS, 1'b1);
    send_packet(XS * YS, XS * YS - 1, 0);
    drain("sat_drain");

    // Early eop on pixel 12, then a clean ramp.
    fill_ramp();
    model_packet(12, 1'b0);
    send_packet(12, 11, 0);
    drain("early_eop_drain");
    check("early_eop_err", 32'(err[0]), 1);
    model_packet(XS * YS, 1'b1);
    send_packet(XS * YS, XS * YS - 1, 1);
    drain("after_err_drain");
    check("err_sticky", 32'(err[0]), 1);

    // Reset after pixel 15.
    model_packet(15, 1'b0);
    send_packet(15, -1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_valid", 32'(oValid[0]), 0);
    check("midreset_err",   32'(err[0]),    0);
    check("midreset_queue", 32'(q.size()),  0);
    rst = 1'b0;
    send_pixel(8'd99, 1'b0, 1'b0, 0);
    model_packet(XS * YS, 1'b1);
    send_packet(XS * YS, XS * YS - 1, 0);
    drain("postreset_drain");
    check("postreset_err", 32'(err[0]), 0);

    // Missing eop: all outputs without eop, trailing beats dropped until eop.
    readyMode = 2;
    fill_random();
    model_packet(XS * YS, 1'b0);
    send_packet(XS * YS, -1, 1);
    send_pixel(8'd1, 1'b0, 1'b0, 0);
    send_pixel(8'd2, 1'b0, 1'b1, 0);
    send_pixel(8'd3, 1'b0, 1'b0, 0);
    drain("discard_drain");
    check("discard_err", 32'(err[0]), 1);

    // Aborted by a second sop, then random clean packets.
    fill_random();
    model_packet(14, 1'b0);
    send_packet(14, -1, 1);
    for (int k = 0; k < 6; k++) begin
      fill_random();
      model_packet(XS * YS, 1'b1);
      send_packet(XS * YS, XS * YS - 1, 2);
      drain("random_drain");
    end
    check("abort_err", 32'(err[0]), 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
